// File: rtl/tcdm_xbar_pipe.sv
// tcdm_xbar_pipe
// ----------------------------------------------------------------------------
// Crossbar from NumIn initiators to NumOut word-interleaved TCDM banks.
// Each bank has a round-robin arbiter. An optional request register slice
// (ReqRegOn=1) sits between the arbiters and the banks. Responses return
// through a per-bank pipeline that is RespLat deep. Per-initiator saturating
// counters record the cycles in which an initiator requested but was not
// granted.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_i/add_i/wen_i/      initiator request: byte address, store flag,
//   wdata_i/be_i            write data and byte enables
//   gnt_o                   request accepted (combinational, same cycle)
//   vld_o/rdata_o           response valid and load data (0 for writes)
//   clr_cnt_i               synchronous clear of all conflict counters
//   conflict_cnt_o          saturating stall counters, one per initiator
//   req_o/add_o/wen_o/      bank-side request: word address inside the
//   wdata_o/be_o            bank, store flag, write data, byte enables
//   gnt_i                   bank grant
//   rdata_i                 bank read data, valid RespLat cycles after the
//                           bank handshake
//
// Handshake: an initiator transfer completes in the cycle where
// req_i & gnt_o is high. A bank transfer completes in the cycle where
// req_o & gnt_i is high. With the register slice enabled, the bank-side
// payload holds stable until that bank handshake.
// ----------------------------------------------------------------------------
module tcdm_xbar_pipe #(
  parameter int unsigned NumIn        = 8,
  parameter int unsigned NumOut       = 16,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned RespLat      = 1,
  parameter int unsigned WriteRespOn  = 1,
  parameter int unsigned ReqRegOn     = 1,
  parameter int unsigned CntWidth     = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumIn-1:0]                     req_i,
  input  logic [NumIn-1:0][AddrWidth-1:0]      add_i,
  input  logic [NumIn-1:0]                     wen_i,
  input  logic [NumIn-1:0][DataWidth-1:0]      wdata_i,
  input  logic [NumIn-1:0][BeWidth-1:0]        be_i,
  output logic [NumIn-1:0]                     gnt_o,
  output logic [NumIn-1:0]                     vld_o,
  output logic [NumIn-1:0][DataWidth-1:0]      rdata_o,
  input  logic                                 clr_cnt_i,
  output logic [NumIn-1:0][CntWidth-1:0]       conflict_cnt_o,
  output logic [NumOut-1:0]                    req_o,
  input  logic [NumOut-1:0]                    gnt_i,
  output logic [NumOut-1:0][AddrMemWidth-1:0]  add_o,
  output logic [NumOut-1:0]                    wen_o,
  output logic [NumOut-1:0][DataWidth-1:0]     wdata_o,
  output logic [NumOut-1:0][BeWidth-1:0]       be_o,
  input  logic [NumOut-1:0][DataWidth-1:0]     rdata_i
);

  localparam int unsigned WordOff  = $clog2(DataWidth / 8);
  localparam int unsigned BankBits = $clog2(NumOut);
  localparam int unsigned BankW    = (BankBits > 0) ? BankBits : 1;
  localparam int unsigned IdxW     = (NumIn > 1) ? $clog2(NumIn) : 1;

  logic [NumIn-1:0][BankW-1:0]         w_bank;
  logic [NumIn-1:0][AddrMemWidth-1:0]  w_waddr;
  logic [NumIn-1:0]                    w_mask;     // initiator has a request parked in a stalled bank
  logic [NumOut-1:0]                   w_any;      // bank has an eligible requester
  logic [NumOut-1:0][IdxW-1:0]         w_win;      // round-robin winner per bank
  logic [NumOut-1:0]                   w_gnt_ev;   // winner is granted (moves the pointer)
  logic [NumOut-1:0]                   w_hs;       // bank handshake this cycle
  logic [NumOut-1:0][IdxW-1:0]         w_hs_idx;
  logic [NumOut-1:0]                   w_hs_wen;
  logic                                w_resp_coll;
  logic                                w_unused_add;

  logic [NumOut-1:0][IdxW-1:0]              r_ptr;
  logic [NumOut-1:0][RespLat-1:0]           r_pv;
  logic [NumOut-1:0][RespLat-1:0][IdxW-1:0] r_pidx;
  logic [NumOut-1:0][RespLat-1:0]           r_pwr;
  logic [NumIn-1:0][CntWidth-1:0]           r_cnt;

  // Address bits above the bank word address are intentionally ignored.
  assign w_unused_add = ^add_i;

  for (genvar m = 0; m < NumIn; m++) begin : g_dec
    if (BankBits > 0) begin : g_bank
      assign w_bank[m] = add_i[m][WordOff +: BankW];
    end else begin : g_one_bank
      assign w_bank[m] = '0;
    end
    assign w_waddr[m] = add_i[m][WordOff+BankBits +: AddrMemWidth];
  end

  // Round-robin search starting at each bank's pointer. rst_ni gates the
  // requests so that no grant is shown while the block is held in reset.
  always_comb begin
    int j;
    j     = 0;
    w_any = '0;
    w_win = '0;
    for (int b = 0; b < NumOut; b++) begin
      for (int k = 0; k < NumIn; k++) begin
        j = int'(r_ptr[b]) + k;
        if (j >= int'(NumIn)) j = j - int'(NumIn);
        if (!w_any[b] && rst_ni && req_i[j] && !w_mask[j] &&
            (w_bank[j] == BankW'(b))) begin
          w_any[b] = 1'b1;
          w_win[b] = IdxW'(j);
        end
      end
    end
  end

  if (ReqRegOn != 0) begin : g_reg
    logic [NumOut-1:0]                   r_vld;
    logic [NumOut-1:0]                   r_wen;
    logic [NumOut-1:0][IdxW-1:0]         r_idx;
    logic [NumOut-1:0][AddrMemWidth-1:0] r_add;
    logic [NumOut-1:0][DataWidth-1:0]    r_wdata;
    logic [NumOut-1:0][BeWidth-1:0]      r_be;

    // Keeping an initiator out of arbitration while its request waits in a
    // stalled bank gives each initiator at most one request in flight
    // toward the banks, so its responses stay in order and never collide.
    always_comb begin
      w_mask = '0;
      for (int b = 0; b < NumOut; b++) begin
        if (r_vld[b] && !gnt_i[b]) w_mask[r_idx[b]] = 1'b1;
      end
    end

    // The slot accepts when it is empty or is draining in this cycle.
    assign w_gnt_ev = w_any & (~r_vld | gnt_i);
    assign w_hs     = r_vld & gnt_i;
    assign w_hs_idx = r_idx;
    assign w_hs_wen = r_wen;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_vld   <= '0;
        r_wen   <= '0;
        r_idx   <= '0;
        r_add   <= '0;
        r_wdata <= '0;
        r_be    <= '0;
      end else begin
        for (int b = 0; b < NumOut; b++) begin
          if (w_gnt_ev[b]) begin
            r_vld[b]   <= 1'b1;
            r_idx[b]   <= w_win[b];
            r_wen[b]   <= wen_i[w_win[b]];
            r_add[b]   <= w_waddr[w_win[b]];
            r_wdata[b] <= wdata_i[w_win[b]];
            r_be[b]    <= be_i[w_win[b]];
          end else if (w_hs[b]) begin
            r_vld[b] <= 1'b0;
          end
        end
      end
    end

    assign req_o   = r_vld;
    assign add_o   = r_add;
    assign wen_o   = r_wen;
    assign wdata_o = r_wdata;
    assign be_o    = r_be;
  end else begin : g_comb
    assign w_mask   = '0;
    assign w_gnt_ev = w_any & gnt_i;
    assign w_hs     = w_any & gnt_i;
    assign w_hs_idx = w_win;
    assign w_hs_wen = wen_o;
    assign req_o    = w_any;

    always_comb begin
      add_o   = '0;
      wen_o   = '0;
      wdata_o = '0;
      be_o    = '0;
      for (int b = 0; b < NumOut; b++) begin
        if (w_any[b]) begin
          add_o[b]   = w_waddr[w_win[b]];
          wen_o[b]   = wen_i[w_win[b]];
          wdata_o[b] = wdata_i[w_win[b]];
          be_o[b]    = be_i[w_win[b]];
        end
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int b = 0; b < NumOut; b++) begin
      if (w_gnt_ev[b]) gnt_o[w_win[b]] = 1'b1;
    end
  end

  // Arbitration pointers and the response shift pipelines.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr  <= '0;
      r_pv   <= '0;
      r_pidx <= '0;
      r_pwr  <= '0;
    end else begin
      for (int b = 0; b < NumOut; b++) begin
        if (w_gnt_ev[b]) begin
          r_ptr[b] <= (w_win[b] == IdxW'(NumIn - 1)) ? '0 : w_win[b] + 1'b1;
        end
        r_pv[b][0]   <= w_hs[b];
        r_pidx[b][0] <= w_hs_idx[b];
        r_pwr[b][0]  <= w_hs_wen[b];
        for (int s = 1; s < int'(RespLat); s++) begin
          r_pv[b][s]   <= r_pv[b][s-1];
          r_pidx[b][s] <= r_pidx[b][s-1];
          r_pwr[b][s]  <= r_pwr[b][s-1];
        end
      end
    end
  end

  always_comb begin
    vld_o       = '0;
    rdata_o     = '0;
    w_resp_coll = 1'b0;
    for (int b = 0; b < NumOut; b++) begin
      if (r_pv[b][RespLat-1] && ((WriteRespOn != 0) || !r_pwr[b][RespLat-1])) begin
        if (vld_o[r_pidx[b][RespLat-1]]) w_resp_coll = 1'b1;
        vld_o[r_pidx[b][RespLat-1]]   = 1'b1;
        rdata_o[r_pidx[b][RespLat-1]] = r_pwr[b][RespLat-1] ? '0 : rdata_i[b];
      end
    end
  end

  // Clear has priority over an increment in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      for (int m = 0; m < NumIn; m++) begin
        if (clr_cnt_i) begin
          r_cnt[m] <= '0;
        end else if (req_i[m] && !gnt_o[m] && (r_cnt[m] != {CntWidth{1'b1}})) begin
          r_cnt[m] <= r_cnt[m] + 1'b1;
        end
      end
    end
  end

  assign conflict_cnt_o = r_cnt;

`ifndef SYNTHESIS
  localparam bit CfgOk = ((NumOut & (NumOut - 1)) == 0) && (NumOut >= NumIn) &&
                         (AddrMemWidth + BankBits + WordOff <= AddrWidth) && (RespLat >= 1);
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (CfgOk);
      assert (!w_resp_coll);
    end
  end
`endif

endmodule

// File: doc/tcdm_xbar_pipe.md
Name: tcdm_xbar_pipe

Overview:
Parametrised next-generation TCDM crossbar connecting NumIn initiators to NumOut word-interleaved banks. Each bank has a round-robin arbiter, and an optional registered request stage breaks the initiator-to-bank timing path. Responses are routed back through a per-bank latency pipeline with a parametric bank latency. Per-initiator saturating conflict counters support performance analysis. The block sits between core/DMA ports and the TCDM bank array, replacing the flat combinational crossbar when timing closure requires a register slice.

Parameters:
NumIn, 8, number of initiator ports (>=1, any value)
NumOut, 16, number of banks (power of 2, >=NumIn)
AddrWidth, 32, initiator byte-address width
DataWidth, 32, data word width (power of 2, >=8)
BeWidth, DataWidth/8, byte-enable width
AddrMemWidth, 12, word-address bits per bank
RespLat, 1, cycles from bank handshake to rdata_i valid (>=1)
WriteRespOn, 1, 1: writes also produce vld_o
ReqRegOn, 1, 1: register request stage toward banks; 0: combinational path
CntWidth, 16, conflict counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NumIn  request
add_i  in  NumIn x AddrWidth  byte address
wen_i  in  NumIn  1 = store, 0 = load
wdata_i  in  NumIn x DataWidth  write data
be_i  in  NumIn x BeWidth  byte enables
gnt_o  out  NumIn  request accepted
vld_o  out  NumIn  response valid
rdata_o  out  NumIn x DataWidth  load data
clr_cnt_i  in  1  synchronous clear of all conflict counters
conflict_cnt_o  out  NumIn x CntWidth  saturating stall counters
req_o  out  NumOut  bank request
gnt_i  in  NumOut  bank grant
add_o  out  NumOut x AddrMemWidth  word address in bank
wen_o  out  NumOut  write enable
wdata_o  out  NumOut x DataWidth  write data
be_o  out  NumOut x BeWidth  byte enables
rdata_i  in  NumOut x DataWidth  bank read data

Behaviour:
- Clock clk_i, reset rst_ni asynchronous active-low. On reset: gnt_o, vld_o, req_o, conflict_cnt_o = 0; rdata_o, add_o, wdata_o, be_o, wen_o = 0; rr pointers = 0; request registers and response pipelines invalid.
- Address decode: WordOff = log2(DataWidth/8). Bank = add_i[WordOff+log2(NumOut)-1 : WordOff]. Bank word address = next AddrMemWidth bits.
- Arbitration, per bank: round-robin among initiators requesting that bank. Priority starts at the pointer. On a handshake the pointer moves to winner+1, wrapping at NumIn. With no handshake, the pointer holds.
- ReqRegOn=0:
  - Bank request path is combinational; gnt_o[m] = arbitration winner & gnt_i[bank].
  - The bank handshake happens in the same cycle as gnt_o.
- ReqRegOn=1:
  - Each bank has one request register (valid + payload + initiator index).
  - The register accepts when empty, or when it is draining this cycle (req_o & gnt_i). gnt_o[m] is asserted on accept.
  - req_o = register valid. Register content holds stable until gnt_i.
  - Ordering rule: an initiator with an accepted but not-yet-handshaken request in any bank register is masked from arbitration. This guarantees in-order, non-colliding responses.
- Response path: each bank has a RespLat-deep shift pipeline of {valid, initiator index, is_write}, loaded on bank handshake.
  - At the pipeline output, the indexed initiator gets vld_o = 1. This is suppressed for writes when WriteRespOn=0.
  - rdata_o = rdata_i of that bank (0 for suppressed or write responses).
  - At most one response per initiator per cycle; a collision is a design error flagged by assertion.
- Latency from gnt_o to vld_o: RespLat cycles when ReqRegOn=0; 1+stall+RespLat cycles when ReqRegOn=1 (stall = cycles gnt_i is low).
- Counters: conflict_cnt_o[m] increments by 1 each cycle req_i[m] & ~gnt_o[m], saturating at all-ones. clr_cnt_i has priority over an increment in the same cycle.
- Reset mid-operation: in-flight requests and responses are dropped, with no vld_o after reset release.
- Assertions (non-synthesised): NumOut power of 2; NumOut>=NumIn; AddrMemWidth+log2(NumOut)+WordOff<=AddrWidth; RespLat>=1.

Test Plan:
- Reset, then single load, NumIn=4, NumOut=8, ReqRegOn=1, RespLat=1: m0 reads add 0x24, gnt_i=1 -> gnt_o[0] at t0; req_o[1] with add_o=1 at t1; vld_o[0] at t2 with rdata_i[1].
- Conflict: m0..m3 all target bank 5 continuously with gnt_i=1 -> grants rotate 0,1,2,3,0; each counter increments 3 per 4 cycles; clr_cnt_i for one cycle -> all counters read 0 the next cycle.
- Bank stall, ReqRegOn=1: gnt_i[2] low for 3 cycles while m1 holds a request to bank 2 -> req_o[2] stable; m1 not granted to bank 3 meanwhile; vld_o[1] arrives RespLat cycles after gnt_i[2] rises.
- Write response mode: WriteRespOn=0, m2 stores -> bank sees wen_o=1 with correct be_o/wdata_o; no vld_o[2]. With WriteRespOn=1, vld_o[2] rises RespLat cycles after the handshake.
- Latency sweep, ReqRegOn=0: RespLat=3, back-to-back loads from m0 to banks 0,1,2 -> gnt_o every cycle; vld_o[0] in three consecutive cycles starting 3 cycles after the first gnt_o, with data in order.
- Saturation/reset: CntWidth=4, 20 stall cycles -> counter holds 15; assert rst_ni mid-transfer -> all outputs 0 immediately, with no stray vld_o after release.
